// File: rtl/data_uploader_if.sv
// RAM read port of the data uploader.
//
// Handshake: the master pulses rd for exactly one clk cycle and holds addr
// constant from that cycle until the cycle in which the slave asserts
// rd_ack. din is only meaningful in the rd_ack cycle. At most one read is
// outstanding. The slave may take any latency of one cycle or more. An
// rd_ack while the master has no read outstanding is ignored.
// fetch_state exposes the master's prefetch FSM for observation.
interface data_uploader_if;
  logic        rd;
  logic [24:0] addr;
  logic [15:0] din;
  logic        rd_ack;
  logic [1:0]  fetch_state;

  modport master (
    output rd,
    output addr,
    output fetch_state,
    input  din,
    input  rd_ack
  );

  modport slave (
    input  rd,
    input  addr,
    input  fetch_state,
    output din,
    output rd_ack
  );
endinterface

// File: rtl/data_uploader.sv
// SPI responder that streams RAM words back to the IO controller.
// SPI lines are oversampled in the clk domain; a one-word prefetch buffer
// is filled over the request/acknowledge RAM port.
module data_uploader #(
  parameter logic [7:0]  CMD_FILE_RX     = 8'h56,
  parameter logic [7:0]  CMD_FILE_RX_DAT = 8'h57,
  parameter logic [24:0] MDV1_BASE       = 25'h380000,
  parameter logic [24:0] MDV2_BASE       = 25'h3C0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sck,
  input  logic            ss,
  input  logic            sdi,
  output logic            sdo,
  input  logic [4:0]      index,
  output logic            uploading,
  output logic            underrun,
  data_uploader_if.master ram
);

  // Prefetch buffer states. F_DROP is a read in flight whose data must be
  // thrown away (session stopped or restarted while it was pending).
  typedef enum logic [1:0] {
    F_EMPTY = 2'd0,
    F_PEND  = 2'd1,
    F_FULL  = 2'd2,
    F_DROP  = 2'd3
  } fetch_t;

  fetch_t      state;
  fetch_t      state_next;

  logic [2:0]  sck_sr;
  logic [1:0]  ss_sr;
  logic [1:0]  sdi_sr;
  logic        ss_sync;
  logic        sdi_sync;
  logic        spi_re;

  logic [4:0]  cnt;
  logic [7:0]  sbuf;
  logic [7:0]  cmd;
  logic [7:0]  cmd_next;
  logic [15:0] shreg;
  logic        sdo_q;
  logic [15:0] word_buf;
  logic [24:0] next_addr;
  logic [24:0] base_addr;
  logic [15:0] load_word;

  logic        start;
  logic        stop;
  logic        load;
  logic        shift;
  logic        rd_issue;
  logic        ack_take;
  logic        buf_full;

  // Two-flop synchronisers; sck keeps a third stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sr <= 3'b000;
      ss_sr  <= 2'b11;
      sdi_sr <= 2'b00;
    end else begin
      sck_sr <= {sck_sr[1:0], sck};
      ss_sr  <= {ss_sr[0], ss};
      sdi_sr <= {sdi_sr[0], sdi};
    end
  end

  assign ss_sync  = ss_sr[1];
  assign sdi_sync = sdi_sr[1];
  assign spi_re   = sck_sr[1] & ~sck_sr[2] & ~ss_sync;
  assign cmd_next = {sbuf[6:0], sdi_sync};

  assign start = spi_re && (cnt == 5'd15) && (cmd == CMD_FILE_RX) && sdi_sync;
  assign stop  = spi_re && (cnt == 5'd15) && (cmd == CMD_FILE_RX) && !sdi_sync;
  // Stop has priority over a word load in the same cycle.
  assign load  = uploading && !stop && spi_re &&
                 (((cnt == 5'd7) && (cmd_next == CMD_FILE_RX_DAT)) ||
                  ((cnt == 5'd23) && (cmd == CMD_FILE_RX_DAT)));
  assign shift = spi_re && (cmd == CMD_FILE_RX_DAT) &&
                 (cnt >= 5'd8) && (cnt <= 5'd22);

  assign load_word = buf_full ? word_buf : 16'hFFFF;

  // Menu index to image base address.
  always_comb begin
    base_addr = 25'd0;
    case (index)
      5'd1:    base_addr = MDV1_BASE;
      5'd2:    base_addr = MDV2_BASE;
      default: base_addr = 25'd0;
    endcase
  end

  // Prefetch FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= F_EMPTY;
    else       state <= state_next;
  end

  // Prefetch FSM next state. An ack coinciding with a load still fills the
  // buffer; the load itself saw it empty.
  always_comb begin
    state_next = state;
    case (state)
      F_EMPTY: if (rd_issue) state_next = F_PEND;
      F_PEND: begin
        if (start || stop) state_next = ram.rd_ack ? F_EMPTY : F_DROP;
        else if (ram.rd_ack) state_next = F_FULL;
      end
      F_FULL:  if (start || load) state_next = F_EMPTY;
      F_DROP:  if (ram.rd_ack) state_next = F_EMPTY;
      default: state_next = F_EMPTY;
    endcase
  end

  // Prefetch FSM outputs: read strobe, accepted ack, buffer-full flag.
  always_comb begin
    rd_issue = 1'b0;
    ack_take = 1'b0;
    buf_full = 1'b0;
    case (state)
      F_EMPTY: rd_issue = uploading && !start && !stop;
      F_PEND:  ack_take = ram.rd_ack && !start && !stop;
      F_FULL:  buf_full = 1'b1;
      default: ;
    endcase
  end

  assign ram.rd          = rd_issue;
  assign ram.addr        = next_addr;
  assign ram.fetch_state = state;

  // Session control, read address, buffer data and sticky underrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      uploading <= 1'b0;
      underrun  <= 1'b0;
      next_addr <= 25'd0;
      word_buf  <= 16'd0;
    end else begin
      if (start) begin
        uploading <= 1'b1;
        underrun  <= 1'b0;
        next_addr <= base_addr;
      end else begin
        if (stop) uploading <= 1'b0;
        if (ack_take) next_addr <= next_addr + 25'd1;
        if (load && !buf_full) underrun <= 1'b1;
      end
      if (ack_take) word_buf <= ram.din;
    end
  end

  // SPI bit counter, command capture and output shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 5'd0;
      sbuf  <= 8'd0;
      cmd   <= 8'd0;
      shreg <= 16'd0;
      sdo_q <= 1'b0;
    end else if (ss_sync) begin
      cnt   <= 5'd0;
      sdo_q <= 1'b0;
    end else if (spi_re) begin
      sbuf <= cmd_next;
      cnt  <= (cnt == 5'd23) ? 5'd8 : cnt + 5'd1;
      if (cnt == 5'd7) cmd <= cmd_next;
      if (load) begin
        shreg <= load_word;
        sdo_q <= load_word[15];
      end else if (shift) begin
        shreg <= {shreg[14:0], 1'b0};
        sdo_q <= shreg[14];
      end
    end
  end

  assign sdo = sdo_q && uploading && (cmd == CMD_FILE_RX_DAT);

endmodule

// File: tb/tb_data_uploader.sv
// Bench for data_uploader: SPI master driver, 3-cycle RAM model, and
// scoreboards for RAM read addresses and streamed words.
module tb_data_uploader;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck;
  logic        ss;
  logic        sdi;
  logic        sdo;
  logic [4:0]  index;
  logic        uploading;
  logic        underrun;

  data_uploader_if ram_bus();

  data_uploader dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .ss        (ss),
    .sdi       (sdi),
    .sdo       (sdo),
    .index     (index),
    .uploading (uploading),
    .underrun  (underrun),
    .ram       (ram_bus)
  );

  // Clock and timeout
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL timeout: simulation did not finish, required finish before 800000 ns");
    $fatal(1, "timeout");
  end

  // Scoreboard state
  logic [24:0] exp_addr_q[$];
  logic [15:0] exp_word_q[$];
  logic [15:0] obs_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ram_lat = 3;
  logic        ram_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ram_data(input logic [24:0] a);
    return 16'(a[15:0] * 16'd3) ^ (a[18] ? 16'hA000 : 16'h0000);
  endfunction

  // RAM model: one outstanding read, ram_lat cycles to ack
  initial begin : ram_model
    logic [24:0] a;
    ram_bus.rd_ack = 1'b0;
    ram_bus.din    = 16'd0;
    forever begin
      @(negedge clk);
      if (ram_bus.rd === 1'b1) begin
        a = ram_bus.addr;
        ram_busy = 1'b1;
        repeat (ram_lat - 1) @(negedge clk);
        ram_bus.din    = ram_data(a);
        ram_bus.rd_ack = 1'b1;
        @(negedge clk);
        ram_bus.rd_ack = 1'b0;
        ram_bus.din    = 16'd0;
        ram_busy = 1'b0;
      end
    end
  end

  // Monitor: every rd strobe against the expected address queue
  initial begin : rd_monitor
    forever begin
      @(negedge clk);
      if (ram_bus.rd === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_addr: unexpected rd at %h, no read required", ram_bus.addr);
        end else begin
          check("rd_addr", 32'(ram_bus.addr), 32'(exp_addr_q.pop_front()));
        end
      end
    end
  end

  // Monitor: every word received by the SPI master against the word queue
  initial begin : word_monitor
    logic [15:0] w;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        w = obs_q.pop_front();
        if (exp_word_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sdo_word: unexpected word %h, no word required", w);
        end else begin
          check("sdo_word", 32'(w), 32'(exp_word_q.pop_front()));
        end
      end
    end
  end

  // SPI master driver tasks (sck = clk/16, sample sdo just before rise)
  task automatic spi_bit(input logic b, output logic s);
    sdi = b;
    repeat (8) @(negedge clk);
    s = sdo;
    sck = 1'b1;
    repeat (8) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) spi_bit(b[i], s);
  endtask

  task automatic spi_begin();
    ss = 1'b0;
  endtask

  task automatic spi_end();
    repeat (8) @(negedge clk);
    ss = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic spi_cmd(input logic [7:0] param);
    spi_begin();
    spi_byte(8'h56);
    spi_byte(param);
    spi_end();
  endtask

  task automatic spi_read(input int n_words, input int tail_bits);
    logic [15:0] word;
    logic        s;
    spi_begin();
    spi_byte(8'h57);
    for (int w = 0; w < n_words; w++) begin
      word = 16'd0;
      for (int b = 0; b < 16; b++) begin
        spi_bit(1'b0, s);
        word = {word[14:0], s};
      end
      obs_q.push_back(word);
    end
    for (int b = 0; b < tail_bits; b++) spi_bit(1'b0, s);
    spi_end();
  endtask

  task automatic wait_ram_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!ram_busy) break;
      @(negedge clk);
    end
    check("ram_ack_wait", 32'(ram_busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sdo"}, 32'(sdo), 32'd0);
    check({tag, "_uploading"}, 32'(uploading), 32'd0);
    check({tag, "_rd"}, 32'(ram_bus.rd), 32'd0);
    check({tag, "_addr"}, 32'(ram_bus.addr), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  // Main stimulus
  initial begin
    reset = 1'b1;
    sck   = 1'b0;
    ss    = 1'b1;
    sdi   = 1'b0;
    index = 5'd0;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // mdv1 session: base 380000, words i*3
    index = 5'd1;
    exp_addr_q.push_back(25'h380000);
    spi_cmd(8'h01);
    check("start1_uploading", 32'(uploading), 32'd1);
    exp_word_q.push_back(16'h0000);
    exp_word_q.push_back(16'h0003);
    exp_word_q.push_back(16'h0006);
    for (int i = 1; i <= 4; i++) exp_addr_q.push_back(25'h380000 + 25'(i));
    spi_read(3, 0);
    check("s1_uploading", 32'(uploading), 32'd1);
    check("s1_underrun", 32'(underrun), 32'd0);

    // two more words, then stop; a later transfer reads zeros, no rd
    exp_word_q.push_back(16'h000C);
    exp_word_q.push_back(16'h000F);
    for (int i = 5; i <= 7; i++) exp_addr_q.push_back(25'h380000 + 25'(i));
    spi_read(2, 0);
    spi_cmd(8'h00);
    check("stop_uploading", 32'(uploading), 32'd0);
    exp_word_q.push_back(16'h0000);
    exp_word_q.push_back(16'h0000);
    spi_read(2, 0);
    check("stopped_uploading", 32'(uploading), 32'd0);
    check("stopped_sdo", 32'(sdo), 32'd0);

    // mdv2 session
    index = 5'd2;
    exp_addr_q.push_back(25'h3C0000);
    spi_cmd(8'h01);
    exp_word_q.push_back(16'hA000);
    exp_addr_q.push_back(25'h3C0001);
    exp_addr_q.push_back(25'h3C0002);
    spi_read(1, 0);
    spi_cmd(8'h00);

    // index 0 selects address 0
    index = 5'd0;
    exp_addr_q.push_back(25'h0);
    spi_cmd(8'h01);
    exp_word_q.push_back(16'h0000);
    exp_word_q.push_back(16'h0003);
    for (int i = 1; i <= 3; i++) exp_addr_q.push_back(25'(i));
    spi_read(2, 0);

    // slow RAM: second word underruns, data later appears at same address
    index = 5'd1;
    exp_addr_q.push_back(25'h380000);
    spi_cmd(8'h01);
    check("u_start_underrun", 32'(underrun), 32'd0);
    ram_lat = 640;
    exp_word_q.push_back(16'h0000);
    exp_word_q.push_back(16'hFFFF);
    exp_addr_q.push_back(25'h380001);
    spi_read(2, 0);
    wait_ram_idle();
    check("u_underrun", 32'(underrun), 32'd1);
    ram_lat = 3;
    exp_word_q.push_back(16'h0003);
    exp_addr_q.push_back(25'h380002);
    exp_addr_q.push_back(25'h380003);
    spi_read(1, 0);

    // ss high mid-word: next transfer resumes with next buffered word
    exp_word_q.push_back(16'h0009);
    exp_addr_q.push_back(25'h380004);
    exp_addr_q.push_back(25'h380005);
    spi_read(1, 7);
    exp_word_q.push_back(16'h000F);
    exp_addr_q.push_back(25'h380006);
    exp_addr_q.push_back(25'h380007);
    spi_read(1, 0);
    check("u_sticky_underrun", 32'(underrun), 32'd1);

    // reset while a read is pending; stale ack must be ignored
    ram_lat = 200;
    exp_addr_q.push_back(25'h380000);
    spi_cmd(8'h01);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    reset = 1'b0;
    wait_ram_idle();
    repeat (2) @(negedge clk);
    check("stale_ack_fetch_state", 32'(ram_bus.fetch_state), 32'd0);
    check("stale_ack_uploading", 32'(uploading), 32'd0);
    ram_lat = 3;
    exp_addr_q.push_back(25'h380000);
    spi_cmd(8'h01);
    exp_word_q.push_back(16'h0000);
    exp_addr_q.push_back(25'h380001);
    exp_addr_q.push_back(25'h380002);
    spi_read(1, 0);

    repeat (20) @(negedge clk);
    check("addr_queue_left", 32'(exp_addr_q.size()), 32'd0);
    check("word_queue_left", 32'(exp_word_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_uploader.md
Name: data_uploader

Overview:
- SPI responder that streams RAM contents back to the IO controller, e.g. saving a modified microdrive image.
- It is the upload counterpart of the download path. It shares sck/ss/sdi with that path and adds sdo.
- It runs entirely in the system clock domain and oversamples the SPI lines.
- It reads 16-bit words through a request/acknowledge RAM port and prefetches one word ahead.

Parameters:
- CMD_FILE_RX, 8'h56, opcode that starts/ends an upload.
- CMD_FILE_RX_DAT, 8'h57, opcode for data streaming.
- MDV1_BASE, 25'h380000, word address of the mdv1_ image.
- MDV2_BASE, 25'h3C0000, word address of the mdv2_ image.

Ports:
- clk  in  1  system clock, frequency ≥ 8× sck.
- reset  in  1  synchronous, active-high.
- sck  in  1  SPI clock from IO controller, asynchronous.
- ss  in  1  SPI select, active high = deselected, asynchronous.
- sdi  in  1  SPI data in, asynchronous.
- sdo  out  1  SPI data out.
- index  in  5  menu index; selects the base address.
- uploading  out  1  upload session active.
- rd  out  1  one-cycle RAM read strobe.
- addr  out  25  RAM word address, held from rd until rd_ack.
- din  in  16  RAM read data, valid with rd_ack.
- rd_ack  in  1  read complete; any latency ≥ 1 cycle.
- underrun  out  1  sticky flag: a word was needed before its data arrived.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: sdo=0, uploading=0, rd=0, addr=0, underrun=0. Bit counter=0, buffer empty, no read pending.
- Synchronisers: sck, ss, sdi each pass through 2 flops. An sck rising edge (re) is detected as sync=1 with the previous sample 0. All SPI actions happen on the re cycle. No falling-edge logic.
- ss_sync=1 forces cnt=0 and sdo=0. Shift register, buffer, pending read, address and uploading are all retained.
- Bit counter cnt counts re: 0..7 is the command byte, then 8..23, wrapping 23→8, as in the download path.
  - sbuf shifts in sdi on every re.
  - At cnt==7, cmd is taken from {sbuf[6:0],sdi}.
- Start/stop: on re at cnt==15 with cmd==CMD_FILE_RX:
  - sdi=1: uploading←1, underrun←0. Base address: index 1→MDV1_BASE, 2→MDV2_BASE, anything else→0. Buffer is invalidated and a read of the base address is issued on the next cycle.
  - sdi=0: uploading←0. Any outstanding read completes, and its data is discarded.
- Prefetch: a read is issued when uploading=1, the buffer is empty and no read is pending.
  - rd is pulsed for 1 cycle with addr = next address.
  - On rd_ack, buf←din, buffer full; the next address becomes addr+1, wrapping at 2^25.
  - rd_ack with no read pending is ignored.
- Word load: a load point is re with cnt==7 and {sbuf[6:0],sdi}==CMD_FILE_RX_DAT, or re with cnt==23 and cmd==CMD_FILE_RX_DAT, in both cases with uploading=1.
  - If buffer full: shreg←buf, buffer marked empty (triggering the next prefetch).
  - Else: shreg←16'hFFFF, underrun←1, and the address is not advanced.
  - sdo←bit 15 of the loaded value on the cycle after re.
- Shift: on re with cmd==CMD_FILE_RX_DAT and cnt in 8..22, shift shreg left and sdo←new bit 15. Data is MSB first. The master samples each bit on the following sck rise.
- sdo is 0 whenever the current command is not CMD_FILE_RX_DAT or uploading=0.
- Simultaneous events:
  - rd_ack in the same cycle as a load point: the load sees the buffer empty. This counts as an underrun, and the acked word is kept for the next load.
  - A load point in the same cycle as the stop command: stop wins.
- Reset mid-operation aborts everything. A later rd_ack is ignored.

Test Plan:
- Setup: RAM model with 3-cycle ack, sck = clk/16.
- index=1, FILE_RX 0x01, RAM[380000+i]=i*3 → first rd at addr 25'h380000 within 4 clk. FILE_RX_DAT for 3 words → sdo streams 0x0000, 0x0003, 0x0006; uploading=1, underrun=0.
- index=2 session start → first rd addr 25'h3C0000. index=0 → addr 0.
- FILE_RX 0x00 after 2 words → uploading=0, sdo stays 0 during a following RX_DAT transfer, no further rd.
- RAM ack delayed 40 sck periods → word reads 16'hFFFF, underrun=1. The next word is the delayed data at the same address.
- ss high mid-word, then a new RX_DAT → streaming resumes with the next buffered word, and the address sequence has no gap.
- reset asserted while a read is pending → all outputs 0 next cycle; a later rd_ack does not set the buffer. A new session restarts at base.
